// File: rtl/ads7805_interface.sv
// Convert/read sequencer for an ADS7805-class 16-bit parallel SAR ADC.
// One start request yields one sample_valid pulse, or a sticky error if BUSY never completes.
module ads7805_interface #(
  parameter int CONV_PULSE_CYCLES = 4,
  parameter int READ_SETUP_CYCLES = 3,
  parameter int TIMEOUT_CYCLES    = 1000,
  parameter int OFFSET_BINARY     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] adc_data,
  input  logic        adc_busy,
  output logic        adc_rc,
  output logic        adc_cs,
  output logic        adc_byte,
  output logic [15:0] sample_value,
  output logic        sample_valid,
  output logic        ready,
  output logic        error
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CONVST    = 3'd1;
  localparam logic [2:0] WAIT_LOW  = 3'd2;
  localparam logic [2:0] WAIT_HIGH = 3'd3;
  localparam logic [2:0] READ      = 3'd4;

  localparam logic [15:0] CONV_LAST    = 16'(CONV_PULSE_CYCLES - 1);
  localparam logic [15:0] READ_LAST    = 16'(READ_SETUP_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic        r_busyMeta;
  logic        r_busySync;
  logic        r_rc;
  logic        r_cs;
  logic [15:0] r_value;
  logic        r_valid;
  logic        r_ready;
  logic        r_error;
  logic [15:0] w_sample;

  assign w_sample     = (OFFSET_BINARY != 0) ? {~adc_data[15], adc_data[14:0]} : adc_data;
  assign adc_rc       = r_rc;
  assign adc_cs       = r_cs;
  assign adc_byte     = 1'b0;
  assign sample_value = r_value;
  assign sample_valid = r_valid;
  assign ready        = r_ready;
  assign error        = r_error;

  // Timeout is checked before the BUSY edge so the shared counter can never run past its limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 16'd0;
      r_busyMeta <= 1'b1;
      r_busySync <= 1'b1;
      r_rc       <= 1'b1;
      r_cs       <= 1'b1;
      r_value    <= 16'd0;
      r_valid    <= 1'b0;
      r_ready    <= 1'b1;
      r_error    <= 1'b0;
    end else begin
      r_busyMeta <= adc_busy;
      r_busySync <= r_busyMeta;
      r_valid    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= CONVST;
            r_cnt   <= 16'd0;
            r_error <= 1'b0;
            r_cs    <= 1'b0;
            r_rc    <= 1'b0;
            r_ready <= 1'b0;
          end
        end
        CONVST: begin
          if (r_cnt == CONV_LAST) begin
            r_state <= WAIT_LOW;
            r_cnt   <= 16'd0;
            r_cs    <= 1'b1;
            r_rc    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        WAIT_LOW, WAIT_HIGH: begin
          if (r_cnt == TIMEOUT_LAST) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_error <= 1'b1;
            r_cs    <= 1'b1;
            r_rc    <= 1'b1;
            r_ready <= 1'b1;
          end else if (r_state == WAIT_LOW && !r_busySync) begin
            r_state <= WAIT_HIGH;
            r_cnt   <= r_cnt + 16'd1;
          end else if (r_state == WAIT_HIGH && r_busySync) begin
            r_state <= READ;
            r_cnt   <= 16'd0;
            r_cs    <= 1'b0;
            r_rc    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        READ: begin
          if (r_cnt == READ_LAST) begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
            r_value <= w_sample;
            r_valid <= 1'b1;
            r_cs    <= 1'b1;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 16'd0;
          r_cs    <= 1'b1;
          r_rc    <= 1'b1;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ads7805_interface.sv
// Directed bench for ads7805_interface: a two's-complement and an offset-binary instance share all stimulus.
module tb_ads7805_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] adcData;
  logic        adcBusy;

  logic        rc0, cs0, byte0, valid0, ready0, error0;
  logic [15:0] value0;
  logic        rc1, cs1, byte1, valid1, ready1, error1;
  logic [15:0] value1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ads7805_interface #(.OFFSET_BINARY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .adc_data(adcData), .adc_busy(adcBusy),
    .adc_rc(rc0), .adc_cs(cs0), .adc_byte(byte0), .sample_value(value0),
    .sample_valid(valid0), .ready(ready0), .error(error0)
  );

  ads7805_interface #(.OFFSET_BINARY(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .adc_data(adcData), .adc_busy(adcBusy),
    .adc_rc(rc1), .adc_cs(cs1), .adc_byte(byte1), .sample_value(value1),
    .sample_valid(valid1), .ready(ready1), .error(error1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Starts a conversion on the next edge; returns just after that edge.
  task automatic applyStimulus(input logic [15:0] data);
    adcData = data;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitRcHigh(input string tag);
    int n = 0;
    while (rc0 !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'd0, rc0}, 32'd1);
  endtask

  task automatic busyPulse(input int lowCycles);
    adcBusy = 1'b0;
    repeat (lowCycles) tick();
    adcBusy = 1'b1;
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (valid0 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'd0, valid0}, 32'd1);
  endtask

  initial begin
    int n;
    int validCount;

    rst = 1'b1;
    start = 1'b0;
    adcData = 16'h0000;
    adcBusy = 1'b1;
    repeat (3) tick();
    checkOutput("reset_rc", {31'd0, rc0}, 32'd1);
    checkOutput("reset_cs", {31'd0, cs0}, 32'd1);
    checkOutput("reset_byte", {31'd0, byte0}, 32'd0);
    checkOutput("reset_value", {16'd0, value0}, 32'd0);
    checkOutput("reset_valid", {31'd0, valid0}, 32'd0);
    checkOutput("reset_ready", {31'd0, ready0}, 32'd1);
    checkOutput("reset_error", {31'd0, error0}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    $display("[TB] nominal conversion");
    applyStimulus(16'h1234);
    checkOutput("nom_ready_low", {31'd0, ready0}, 32'd0);
    checkOutput("nom_cs_low", {31'd0, cs0}, 32'd0);
    n = 0;
    while (rc0 === 1'b0 && n < 20) begin
      n++;
      tick();
    end
    checkOutput("nom_rc_low_width", n, 32'd4);
    checkOutput("nom_cs_after_conv", {31'd0, cs0}, 32'd1);
    busyPulse(400);
    n = 0;
    while (cs0 !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("nom_read_cs_low", {31'd0, cs0}, 32'd0);
    checkOutput("nom_read_rc_high", {31'd0, rc0}, 32'd1);
    n = 0;
    while (cs0 === 1'b0 && n < 20) begin
      checkOutput("nom_no_early_valid", {31'd0, valid0}, 32'd0);
      n++;
      tick();
    end
    checkOutput("nom_read_width", n, 32'd3);
    checkOutput("nom_valid", {31'd0, valid0}, 32'd1);
    checkOutput("nom_value", {16'd0, value0}, 32'h1234);
    checkOutput("nom_value_offset", {16'd0, value1}, 32'h9234);
    checkOutput("nom_ready_back", {31'd0, ready0}, 32'd1);
    tick();
    checkOutput("nom_valid_single", {31'd0, valid0}, 32'd0);
    checkOutput("nom_value_hold", {16'd0, value0}, 32'h1234);

    $display("[TB] offset binary codes");
    applyStimulus(16'h8000);
    waitRcHigh("ob1_rc");
    busyPulse(20);
    waitValid("ob1_valid");
    checkOutput("ob1_twos", {16'd0, value0}, 32'h8000);
    checkOutput("ob1_offset", {16'd0, value1}, 32'h0000);
    applyStimulus(16'h7FFF);
    waitRcHigh("ob2_rc");
    busyPulse(20);
    waitValid("ob2_valid");
    checkOutput("ob2_twos", {16'd0, value0}, 32'h7FFF);
    checkOutput("ob2_offset", {16'd0, value1}, 32'hFFFF);

    $display("[TB] busy timeout");
    applyStimulus(16'h0F0F);
    n = 0;
    validCount = 0;
    while (error0 !== 1'b1 && n < 1100) begin
      tick();
      n++;
      if (valid0 === 1'b1) validCount++;
    end
    checkOutput("to_error", {31'd0, error0}, 32'd1);
    checkOutput("to_window", {31'd0, (n >= 1003 && n <= 1005)}, 32'd1);
    checkOutput("to_no_valid", validCount, 32'd0);
    checkOutput("to_cs", {31'd0, cs0}, 32'd1);
    checkOutput("to_rc", {31'd0, rc0}, 32'd1);
    checkOutput("to_ready", {31'd0, ready0}, 32'd1);
    checkOutput("to_value_kept", {16'd0, value0}, 32'h7FFF);
    repeat (5) tick();
    checkOutput("to_error_sticky", {31'd0, error0}, 32'd1);
    applyStimulus(16'h4321);
    checkOutput("to_error_cleared", {31'd0, error0}, 32'd0);
    waitRcHigh("to_next_rc");
    busyPulse(30);
    waitValid("to_next_valid");
    checkOutput("to_next_value", {16'd0, value0}, 32'h4321);

    $display("[TB] start ignored while busy");
    applyStimulus(16'h0BCD);
    waitRcHigh("ign_rc");
    adcBusy = 1'b0;
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("ign_ready_low", {31'd0, ready0}, 32'd0);
    repeat (30) tick();
    adcBusy = 1'b1;
    validCount = 0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (valid0 === 1'b1) validCount++;
    end
    checkOutput("ign_one_sample", validCount, 32'd1);
    checkOutput("ign_no_error", {31'd0, error0}, 32'd0);
    checkOutput("ign_value", {16'd0, value0}, 32'h0BCD);
    checkOutput("ign_idle_cs", {31'd0, cs0}, 32'd1);

    $display("[TB] back-to-back conversions");
    applyStimulus(16'hAAAA);
    waitRcHigh("b2b_rc1");
    busyPulse(40);
    waitValid("b2b_valid1");
    checkOutput("b2b_value1", {16'd0, value0}, 32'hAAAA);
    applyStimulus(16'h5555);
    checkOutput("b2b_cs_low", {31'd0, cs0}, 32'd0);
    checkOutput("b2b_rc_low", {31'd0, rc0}, 32'd0);
    checkOutput("b2b_ready_low", {31'd0, ready0}, 32'd0);
    checkOutput("b2b_value1_hold", {16'd0, value0}, 32'hAAAA);
    waitRcHigh("b2b_rc2");
    busyPulse(40);
    waitValid("b2b_valid2");
    checkOutput("b2b_value2", {16'd0, value0}, 32'h5555);

    $display("[TB] async reset during read");
    applyStimulus(16'h2222);
    waitRcHigh("ar_rc");
    busyPulse(30);
    n = 0;
    while (cs0 !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    checkOutput("ar_in_read", {31'd0, cs0}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("ar_cs", {31'd0, cs0}, 32'd1);
    checkOutput("ar_rc", {31'd0, rc0}, 32'd1);
    checkOutput("ar_ready", {31'd0, ready0}, 32'd1);
    checkOutput("ar_valid", {31'd0, valid0}, 32'd0);
    checkOutput("ar_value", {16'd0, value0}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ads7805_interface.md
# ads7805_interface

Read-side companion to the DAC712 output stage: drives a Burr-Brown ADS7805-class 16-bit parallel SAR ADC through a full convert/read cycle and returns one sample per request. It sits between the suspension sensor front-end (accelerometer or displacement ADC) and the controller datapath, and exposes a single start/valid handshake. The block owns the ADC control pins (R/C, CS, BYTE), synchronises the asynchronous BUSY line and bounds every wait with a timeout.

## Interface
- CONV_PULSE_CYCLES, 4: clock cycles R/C and CS are held low to start a conversion (1..65535).
- READ_SETUP_CYCLES, 3: clock cycles CS is held low with R/C high before data capture (1..65535).
- TIMEOUT_CYCLES, 1000: maximum cycles spent waiting on BUSY (1..65535); 20 µs at 50 MHz.
- OFFSET_BINARY, 0: 0 = pass ADC two's-complement code unchanged; 1 = invert bit 15 (offset binary).

- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one conversion; honoured only while ready=1.
- adc_data  input  16  ADC parallel data bus.
- adc_busy  input  1  ADC BUSY (low while converting); asynchronous to clk.
- adc_rc  output  1  ADC R/C (0 = convert, 1 = read).
- adc_cs  output  1  ADC CS, active low.
- adc_byte  output  1  ADC BYTE select; constant 0 (full 16-bit word).
- sample_value  output  16  last captured sample.
- sample_valid  output  1  one-cycle pulse when sample_value updates.
- ready  output  1  1 in IDLE; start accepted.
- error  output  1  sticky BUSY-timeout flag.

## Operation
- All outputs registered. Reset values: adc_rc=1, adc_cs=1, adc_byte=0, sample_value=0, sample_valid=0, ready=1, error=0; FSM=IDLE, counters=0, synchroniser=1.
- adc_busy passes through a 2-flop synchroniser (busy_s), reset value 1.
- States:
  - IDLE: ready=1, cs=1, rc=1. start=1 -> CONVST, clear error, load counter.
  - CONVST: cs=0, rc=0 for exactly CONV_PULSE_CYCLES cycles -> WAIT_LOW; cs=1, rc=1.
  - WAIT_LOW: wait for busy_s=0 -> WAIT_HIGH.
  - WAIT_HIGH: wait for busy_s=1 -> READ.
  - READ: cs=0, rc=1 for exactly READ_SETUP_CYCLES cycles; on the edge leaving READ: capture adc_data (bit 15 inverted if OFFSET_BINARY=1) into sample_value, pulse sample_valid, cs=1, -> IDLE.
- Timeout: one 16-bit counter cleared on entry to WAIT_LOW, runs through WAIT_LOW and WAIT_HIGH. When it reaches TIMEOUT_CYCLES before READ: error=1, cs=1, rc=1, -> IDLE; no sample_valid, sample_value unchanged.
- start while ready=0 is ignored (not queued).
- error stays 1 until the next accepted start or reset.
- rst mid-operation: immediately returns all outputs to reset values, including releasing cs mid-conversion or mid-read.

## Timing
- Start accepted on edge E0; adc_cs/adc_rc fall and ready falls in the cycle after E0.
- rc low width = CONV_PULSE_CYCLES clocks exactly.
- BUSY observation latency = 2 clocks (synchroniser).
- Total latency start -> sample_valid = 1 + CONV_PULSE_CYCLES + (cycles in WAIT_LOW/WAIT_HIGH) + READ_SETUP_CYCLES.
- sample_valid high exactly 1 cycle, coincident with the new sample_value and with ready=1. A start in that same cycle is accepted (back-to-back conversions, no idle gap).
- BUSY pulse shorter than 2 clocks may be missed -> timeout path; this is the required behaviour.

## Test plan
- Nominal: start pulse, BUSY model low for 400 cycles, adc_data=16'h1234 -> rc low 4 cycles, cs low 3 cycles in READ, sample_value=16'h1234, sample_valid single pulse, ready back to 1.
- OFFSET_BINARY=1, adc_data=16'h8000 -> sample_value=16'h0000; adc_data=16'h7FFF -> 16'hFFFF.
- Timeout: BUSY held high forever -> after 1000 wait cycles error=1, cs=1, no sample_valid, sample_value retains prior value; next start clears error.
- Ignored start: pulse start during WAIT_HIGH -> exactly one conversion, one sample_valid.
- Back-to-back: start asserted in the sample_valid cycle -> next CONVST begins the following cycle; two samples 16'hAAAA then 16'h5555 are captured in order.
- Async reset asserted during READ (cs=0) -> cs=1, rc=1, ready=1, sample_valid=0, sample_value=0 without waiting for a clock edge.
